l2_req_gen: RTL and testbench

Converts line-request credits from the L2 stream pointer into OpenCAPI 3.0 read commands with cache-line effective addresses and tags. Completions may return out of order; the block returns them to the stream pointer strictly in issue order. The stream pointer only sees its request/response handshakes, and the in-order line index doubles as the URAM write pointer. One instance per stream, between the stream pointer and the TLX command/response ports.

---
 rtl/l2_req_gen.sv | 171 +++++++++++++++++
 tb/tb_l2_req_gen.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : l2_req_gen
// Desc     : Turns stream-pointer line credits into TLX read commands and
//            retires out-of-order completions back in issue order.
//            Optional macro L2_REQ_GEN_SPURIOUS_CHK_EN drops completions that
//            fall outside the outstanding window or repeat a done tag.
// Revision : 1.0  initial release
// ============================================================================
module l2_req_gen #(
  parameter int L2_NCL       = 256,
  parameter int L2_NCL_WIDTH = $clog2(L2_NCL),
  parameter int CL_BYTES     = 128,
  parameter int MAX_OUT      = 32,
  parameter int OUT_WIDTH    = $clog2(MAX_OUT + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_base_v,
  output logic                    i_base_r,
  input  logic [63:0]             i_base_ea,
  input  logic                    i_flush_v,
  output logic                    i_flush_r,
  input  logic                    i_req_v,
  output logic                    i_req_r,
  output logic                    o_cmd_v,
  input  logic                    o_cmd_r,
  output logic [63:0]             o_cmd_ea,
  output logic [L2_NCL_WIDTH-1:0] o_cmd_tag,
  input  logic                    i_rsp_v,
  output logic                    i_rsp_r,
  input  logic [L2_NCL_WIDTH-1:0] i_rsp_tag,
  input  logic                    i_rsp_err,
  output logic                    o_rsp_v,
  input  logic                    o_rsp_r,
  output logic [L2_NCL_WIDTH-1:0] o_wr_ptr,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [L2_NCL_WIDTH-1:0] c_PTR_LAST = L2_NCL_WIDTH'(L2_NCL - 1);
  localparam logic [L2_NCL_WIDTH-1:0] c_PTR_ONE  = L2_NCL_WIDTH'(1);
  localparam logic [OUT_WIDTH-1:0]    c_OUT_MAX  = OUT_WIDTH'(MAX_OUT);
  localparam logic [OUT_WIDTH-1:0]    c_OUT_ONE  = OUT_WIDTH'(1);
  localparam logic [63:0]             c_EA_STEP  = 64'(CL_BYTES);

  logic [1:0]              r_state;
  logic [63:0]             r_ea;
  logic [L2_NCL_WIDTH-1:0] r_iss_ptr;
  logic [L2_NCL_WIDTH-1:0] r_ret_ptr;
  logic [OUT_WIDTH-1:0]    r_out;
  logic [L2_NCL-1:0]       r_done;
  logic                    r_err;

  logic w_base_hs;
  logic w_flush_hs;
  logic w_issue;
  logic w_retire;
  logic w_rsp_ok;
  logic w_rsp_set;
  logic w_err_set;

  function automatic logic [L2_NCL_WIDTH-1:0] f_ptr_inc(input logic [L2_NCL_WIDTH-1:0] p);
    f_ptr_inc = (p == c_PTR_LAST) ? '0 : p + c_PTR_ONE;
  endfunction

  assign o_cmd_v   = (r_state == c_RUN) & i_req_v & (r_out < c_OUT_MAX);
  assign i_req_r   = o_cmd_v & o_cmd_r;
  assign w_issue   = i_req_r;
  assign o_rsp_v   = r_done[r_ret_ptr];
  assign w_retire  = o_rsp_v & o_rsp_r;
  assign i_base_r  = (r_state == c_IDLE) | ((r_state == c_RUN) & (r_out == '0));
  assign i_flush_r = (r_state == c_RUN);
  assign i_rsp_r   = 1'b1;
  assign w_base_hs  = i_base_v & i_base_r;
  assign w_flush_hs = i_flush_v & i_flush_r;

  assign o_cmd_ea  = r_ea;
  assign o_cmd_tag = r_iss_ptr;
  assign o_wr_ptr  = r_ret_ptr;
  assign o_busy    = (r_state != c_IDLE);
  assign o_err     = r_err;

`ifdef L2_REQ_GEN_SPURIOUS_CHK_EN
  // Distance of the tag from the retire pointer, modulo the line count.
  localparam logic [L2_NCL_WIDTH:0] c_NCL_EXT = (L2_NCL_WIDTH + 1)'(L2_NCL);
  logic [L2_NCL_WIDTH:0] w_rsp_off;
  always_comb begin
    w_rsp_off = '0;
    if (i_rsp_tag >= r_ret_ptr)
      w_rsp_off = {1'b0, i_rsp_tag} - {1'b0, r_ret_ptr};
    else
      w_rsp_off = {1'b0, i_rsp_tag} + c_NCL_EXT - {1'b0, r_ret_ptr};
  end
  assign w_rsp_ok = (32'(w_rsp_off) < 32'(r_out)) & ~r_done[i_rsp_tag];
`else
  assign w_rsp_ok = 1'b1;
`endif

  assign w_rsp_set = i_rsp_v & w_rsp_ok;
  assign w_err_set = i_rsp_v & (i_rsp_err | ~w_rsp_ok);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (w_base_hs) r_state <= c_RUN;
        c_RUN:   if (w_flush_hs) r_state <= c_DRAIN;
        c_DRAIN: if ((r_out == '0) && !o_rsp_v) r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // A base load only happens with nothing outstanding, so it simply restarts everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ea      <= '0;
      r_iss_ptr <= '0;
      r_ret_ptr <= '0;
      r_out     <= '0;
    end else if (w_base_hs) begin
      r_ea      <= i_base_ea;
      r_iss_ptr <= '0;
      r_ret_ptr <= '0;
      r_out     <= '0;
    end else begin
      if (w_issue) begin
        r_ea      <= r_ea + c_EA_STEP;
        r_iss_ptr <= f_ptr_inc(r_iss_ptr);
      end
      if (w_retire)
        r_ret_ptr <= f_ptr_inc(r_ret_ptr);
      case ({w_issue, w_retire})
        2'b10:   r_out <= r_out + c_OUT_ONE;
        2'b01:   r_out <= r_out - c_OUT_ONE;
        default: r_out <= r_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_done <= '0;
    end else if (w_base_hs) begin
      r_done <= '0;
    end else begin
      if (w_rsp_set)
        r_done[i_rsp_tag] <= 1'b1;
      if (w_retire)
        r_done[r_ret_ptr] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_base_hs) begin
      r_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_req_gen
// Desc     : Scoreboard bench for l2_req_gen with a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_l2_req_gen;

  localparam int NCL  = 256;
  localparam int MAXO = 32;
  localparam int CLB  = 128;
  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_base_v = 1'b0;
  logic        i_base_r;
  logic [63:0] i_base_ea = '0;
  logic        i_flush_v = 1'b0;
  logic        i_flush_r;
  logic        i_req_v = 1'b0;
  logic        i_req_r;
  logic        o_cmd_v;
  logic        o_cmd_r = 1'b1;
  logic [63:0] o_cmd_ea;
  logic [7:0]  o_cmd_tag;
  logic        i_rsp_v = 1'b0;
  logic        i_rsp_r;
  logic [7:0]  i_rsp_tag = '0;
  logic        i_rsp_err = 1'b0;
  logic        o_rsp_v;
  logic        o_rsp_r = 1'b1;
  logic [7:0]  o_wr_ptr;
  logic        o_busy;
  logic        o_err;

  l2_req_gen u_dut (
    .clk       (clk),
    .reset     (rst_n),
    .i_base_v  (i_base_v),
    .i_base_r  (i_base_r),
    .i_base_ea (i_base_ea),
    .i_flush_v (i_flush_v),
    .i_flush_r (i_flush_r),
    .i_req_v   (i_req_v),
    .i_req_r   (i_req_r),
    .o_cmd_v   (o_cmd_v),
    .o_cmd_r   (o_cmd_r),
    .o_cmd_ea  (o_cmd_ea),
    .o_cmd_tag (o_cmd_tag),
    .i_rsp_v   (i_rsp_v),
    .i_rsp_r   (i_rsp_r),
    .i_rsp_tag (i_rsp_tag),
    .i_rsp_err (i_rsp_err),
    .o_rsp_v   (o_rsp_v),
    .o_rsp_r   (o_rsp_r),
    .o_wr_ptr  (o_wr_ptr),
    .o_busy    (o_busy),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] ea;
    int          tag;
  } cmd_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_iss = 0;
  int   n_ret = 0;
  int   m_st = ST_IDLE;
  int   m_out = 0;
  bit   m_err = 1'b0;
  bit   m_done [NCL];
  int   ret_q [$];
  int   pool [$];
  cmd_t exp_cmd_q [$];
  logic [63:0] gen_base = '0;
  int   gen_n = 0;

  bit   e_cmdv, e_rspv, e_baser, cmd_hs, rsp_hs, rsp_ok, drain_go;
  int   st_now, t_ret;
  cmd_t c_exp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s timeout actual=stuck required=done", nm);
  endtask

  // Monitor / scoreboard: samples settled outputs mid-cycle and advances the model.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      m_st = ST_IDLE;
      m_out = 0;
      m_err = 1'b0;
      ret_q.delete();
      foreach (m_done[i]) m_done[i] = 1'b0;
    end else begin
      st_now  = m_st;
      e_cmdv  = (st_now == ST_RUN) && i_req_v && (m_out < MAXO);
      e_rspv  = (ret_q.size() > 0) && m_done[ret_q[0]];
      e_baser = (st_now == ST_IDLE) || (st_now == ST_RUN && m_out == 0);
      chk("cmd_v",   64'(o_cmd_v),   64'(e_cmdv));
      chk("req_r",   64'(i_req_r),   64'(e_cmdv && o_cmd_r));
      chk("rsp_v",   64'(o_rsp_v),   64'(e_rspv));
      chk("base_r",  64'(i_base_r),  64'(e_baser));
      chk("flush_r", 64'(i_flush_r), 64'(st_now == ST_RUN));
      chk("rsp_r",   64'(i_rsp_r),   64'(1));
      chk("busy",    64'(o_busy),    64'(st_now != ST_IDLE));
      chk("err",     64'(o_err),     64'(m_err));
      if (e_rspv) chk("wr_ptr", 64'(o_wr_ptr), 64'(ret_q[0]));

      drain_go = (st_now == ST_DRAIN) && (m_out == 0) && !e_rspv;
      cmd_hs = o_cmd_v && o_cmd_r;
      rsp_hs = o_rsp_v && o_rsp_r && (ret_q.size() > 0);

      rsp_ok = 1'b1;
`ifdef L2_REQ_GEN_SPURIOUS_CHK_EN
      if (i_rsp_v) begin
        rsp_ok = 1'b0;
        foreach (ret_q[i]) if (ret_q[i] == int'(i_rsp_tag)) rsp_ok = 1'b1;
        if (m_done[i_rsp_tag]) rsp_ok = 1'b0;
      end
`endif

      if (cmd_hs) begin
        if (exp_cmd_q.size() == 0) begin
          timeout_fail("cmd_unexpected");
        end else begin
          c_exp = exp_cmd_q.pop_front();
          chk("cmd_ea",  o_cmd_ea,          c_exp.ea);
          chk("cmd_tag", 64'(o_cmd_tag),    64'(c_exp.tag));
          ret_q.push_back(c_exp.tag);
          pool.push_back(c_exp.tag);
        end
        m_out++;
        n_iss++;
      end
      if (rsp_hs) begin
        t_ret = ret_q.pop_front();
        m_done[t_ret] = 1'b0;
        m_out--;
        n_ret++;
      end
      if (i_rsp_v && rsp_ok) m_done[i_rsp_tag] = 1'b1;
      if (i_rsp_v && (i_rsp_err || !rsp_ok)) m_err = 1'b1;

      if (drain_go) m_st = ST_IDLE;
      if (i_flush_v && st_now == ST_RUN) m_st = ST_DRAIN;
      if (i_base_v && e_baser) begin
        m_st = ST_RUN;
        m_out = 0;
        m_err = 1'b0;
        ret_q.delete();
        foreach (m_done[i]) m_done[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    while (exp_cmd_q.size() < 4) begin
      exp_cmd_q.push_back('{gen_base + 64'(gen_n) * 64'(CLB), gen_n % NCL});
      gen_n++;
    end
  endtask

  task automatic pool_rm(input int tag);
    foreach (pool[i]) begin
      if (pool[i] == tag) begin
        pool.delete(i);
        break;
      end
    end
  endtask

  task automatic load_base(input logic [63:0] ea);
    tick();
    i_base_v = 1'b1;
    i_base_ea = ea;
    exp_cmd_q.delete();
    gen_base = ea;
    gen_n = 0;
    tick();
    i_base_v = 1'b0;
  endtask

  task automatic issue_n(input int n);
    int tgt = n_iss + n;
    int k = 0;
    while (n_iss < tgt && k < 500) begin
      tick();
      i_req_v = (n_iss < tgt);
      k++;
    end
    i_req_v = 1'b0;
    if (n_iss < tgt) timeout_fail("issue_n");
  endtask

  task automatic complete(input int tag, input bit err);
    tick();
    i_rsp_v = 1'b1;
    i_rsp_tag = 8'(tag);
    i_rsp_err = err;
    pool_rm(tag);
    tick();
    i_rsp_v = 1'b0;
    i_rsp_err = 1'b0;
  endtask

  task automatic complete_all();
    int idx;
    while (pool.size() > 0) begin
      idx = int'($urandom_range(pool.size() - 1));
      complete(pool[idx], 1'b0);
    end
  endtask

  task automatic wait_out0(input string nm);
    int k = 0;
    while ((m_out != 0 || ret_q.size() != 0) && k < 400) begin
      tick();
      #3;
      k++;
    end
    if (k >= 400) timeout_fail(nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, r0, cnt, idx, tgt;

    rst_n = 1'b0;
    repeat (3) tick();
    #1;
    chk("rst_cmd_v",   64'(o_cmd_v),   0);
    chk("rst_rsp_v",   64'(o_rsp_v),   0);
    chk("rst_req_r",   64'(i_req_r),   0);
    chk("rst_flush_r", 64'(i_flush_r), 0);
    chk("rst_busy",    64'(o_busy),    0);
    chk("rst_err",     64'(o_err),     0);
    chk("rst_base_r",  64'(i_base_r),  1);
    chk("rst_cmd_ea",  o_cmd_ea,       0);
    chk("rst_cmd_tag", 64'(o_cmd_tag), 0);
    chk("rst_wr_ptr",  64'(o_wr_ptr),  0);
    pool.delete();
    rst_n = 1'b1;

    // Basic in-order flow
    load_base(64'h1000);
    r0 = n_ret;
    issue_n(4);
    for (int t = 0; t < 4; t++) complete(t, 1'b0);
    wait_out0("basic_drain");
    chk("basic_retires", 64'(n_ret - r0), 4);

    // Out-of-order completions retire in order, back to back
    load_base(64'h2000);
    issue_n(4);
    complete(3, 1'b0);
    complete(1, 1'b0);
    complete(2, 1'b0);
    repeat (3) tick();
    #1;
    chk("ooo_hold", 64'(o_rsp_v), 0);
    tick();
    i_rsp_v = 1'b1;
    i_rsp_tag = 8'd0;
    pool_rm(0);
    cnt = 0;
    while (cnt < 20) begin
      tick();
      i_rsp_v = 1'b0;
      #3;
      cnt++;
      if (m_out == 0) break;
    end
    chk("ooo_consec", 64'(cnt), 4);

    // Outstanding cap
    load_base(64'h4000);
    k0 = n_iss;
    i_req_v = 1'b1;
    repeat (50) tick();
    #1;
    chk("cap_count", 64'(n_iss - k0), 32);
    chk("cap_cmd_v", 64'(o_cmd_v), 0);
    complete(0, 1'b0);
    repeat (10) tick();
    #1;
    chk("cap_one_more", 64'(n_iss - k0), 33);
    i_req_v = 1'b0;
    complete_all();
    wait_out0("cap_drain");

    // Pointer and EA wrap under random traffic
    load_base(64'hFFFF_FFFF_FFFF_FF00);
    k0 = n_iss;
    tgt = n_iss + 258;
    cnt = 0;
    while ((n_iss < tgt || m_out > 0 || pool.size() > 0) && cnt < 5000) begin
      tick();
      i_req_v = (n_iss < tgt) && ($urandom_range(3) != 0);
      o_cmd_r = ($urandom_range(3) != 0);
      o_rsp_r = ($urandom_range(2) != 0);
      if (pool.size() > 0 && $urandom_range(1) == 1) begin
        idx = int'($urandom_range(pool.size() - 1));
        i_rsp_v = 1'b1;
        i_rsp_tag = 8'(pool[idx]);
        i_rsp_err = ($urandom_range(15) == 0);
        pool.delete(idx);
      end else begin
        i_rsp_v = 1'b0;
        i_rsp_err = 1'b0;
      end
      cnt++;
    end
    if (cnt >= 5000) timeout_fail("wrap_run");
    i_req_v = 1'b0;
    i_rsp_v = 1'b0;
    i_rsp_err = 1'b0;
    o_cmd_r = 1'b1;
    o_rsp_r = 1'b1;
    wait_out0("wrap_drain");
    chk("wrap_count", 64'(n_iss - k0), 258);

    // Flush with 5 outstanding
    load_base(64'h8000);
    issue_n(5);
    tick();
    i_flush_v = 1'b1;
    tick();
    i_flush_v = 1'b0;
    i_req_v = 1'b1;
    k0 = n_iss;
    repeat (4) tick();
    #1;
    chk("flush_busy", 64'(o_busy), 1);
    chk("flush_noissue", 64'(n_iss - k0), 0);
    i_req_v = 1'b0;
    for (int t = 0; t < 5; t++) complete(t, 1'b0);
    cnt = 0;
    while (o_busy && cnt < 20) begin
      tick();
      #3;
      cnt++;
    end
    chk("flush_idle", 64'(o_busy), 0);
    chk("flush_base_r", 64'(i_base_r), 1);

    // Error completion is sticky until the next base load
    load_base(64'h9000);
    issue_n(1);
    complete(0, 1'b1);
    wait_out0("err_drain");
    tick();
    #1;
    chk("err_sticky", 64'(o_err), 1);
    load_base(64'hA000);
    #1;
    chk("err_clear", 64'(o_err), 0);

`ifdef L2_REQ_GEN_SPURIOUS_CHK_EN
    load_base(64'hB000);
    issue_n(4);
    complete(9, 1'b0);
    #1;
    chk("spur_err", 64'(o_err), 1);
    chk("spur_rsp_v", 64'(o_rsp_v), 0);
    for (int t = 0; t < 4; t++) complete(t, 1'b0);
    wait_out0("spur_drain");
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
